// File: rtl/gpio_pkg.sv
// gpio_pkg: shared register-offset constants and the offset type for the
// memory-mapped GPIO peripheral.
package gpio_pkg;

  // Word offset inside the 4-word register window.
  typedef logic [1:0] gpio_off_t;

  localparam gpio_off_t OFF_SW_VAL   = 2'd0;
  localparam gpio_off_t OFF_LED      = 2'd1;
  localparam gpio_off_t OFF_CHANGED  = 2'd2;
  localparam gpio_off_t OFF_IRQ_MASK = 2'd3;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-flop synchroniser plus tick-sampled debouncer with a
// prime step after reset. Emits the debounced vector and a one-cycle
// per-bit change pulse aligned with the edge that updates it.
// Build option: GPIO_DEBOUNCE_EN. When undefined, the prescaler and tick
// sampling are removed and the debounced vector is the synchroniser output.
module gpio_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o,
  output logic [WIDTH-1:0] chg_o
);

  if (WIDTH < 1 || DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("gpio_debounce: WIDTH must be >= 1 and DEBOUNCE_CYCLES >= 2");
  end

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] chg_s;
  logic             prime_q, prime_d;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_s;

  // Two-stage synchroniser; deliberately not reset so it tracks pins during reset.
  always_ff @(posedge clock) begin
    sync1_q <= raw_i;
    sync2_q <= sync1_q;
  end

  // Prescaler, tick sampling, prime and agreement-based acceptance.
  always_comb begin
    tick_s  = (cnt_q == '0);
    cnt_d   = tick_s ? CNT_MAX : (cnt_q - CNT_W'(1));
    samp_d  = samp_q;
    deb_d   = deb_q;
    prime_d = prime_q;
    chg_s   = '0;
    if (tick_s) begin
      samp_d = sync2_q;
      if (prime_q) begin
        deb_d   = sync2_q;
        prime_d = 1'b0;
      end else begin
        // Accept a bit only when two consecutive tick samples agree on a new value.
        chg_s = ~(sync2_q ^ samp_q) & (sync2_q ^ deb_q);
        deb_d = deb_q ^ chg_s;
      end
    end else begin
      chg_s = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= CNT_MAX;
      samp_q  <= '0;
      deb_q   <= '0;
      prime_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
      prime_q <= prime_d;
    end
  end
`else
  // First synchroniser stage; deb_q acts as the second stage.
  always_ff @(posedge clock) begin
    sync1_q <= raw_i;
  end

  // Pass-through: prime on the first cycle after reset, then report every change.
  always_comb begin
    deb_d   = sync1_q;
    prime_d = 1'b0;
    if (prime_q) begin
      chg_s = '0;
    end else begin
      chg_s = sync1_q ^ deb_q;
    end
  end

  // Second synchroniser stage / debounced value and prime flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q   <= '0;
      prime_q <= 1'b1;
    end else begin
      deb_q   <= deb_d;
      prime_q <= prime_d;
    end
  end
`endif

  assign deb_o = deb_q;
  assign chg_o = chg_s;

endmodule

// File: rtl/gpio_mapped_io.sv
// gpio_mapped_io: memory-mapped GPIO with debounced switches, sticky
// write-1-to-clear change flags, maskable level interrupt and LED register.
// Build option: GPIO_DEBOUNCE_EN (enables the debounce prescaler in gpio_debounce).
module gpio_mapped_io
  import gpio_pkg::*;
#(
  parameter int                DATA_W          = 16,
  parameter int                ADDR_W          = 16,
  parameter int                IN_W            = 16,
  parameter int                OUT_W           = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'hFFF0,
  parameter int                DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  input  logic [IN_W-1:0]   switches,
  output logic [OUT_W-1:0]  leds,
  output logic              irq
);

  if (IN_W < 1 || IN_W > DATA_W || OUT_W < 1 || OUT_W > DATA_W ||
      BASE_ADDR[1:0] != 2'b00) begin : g_param_check
    $error("gpio_mapped_io: illegal IN_W/OUT_W or unaligned BASE_ADDR");
  end

  logic [IN_W-1:0]   deb_s, chg_s, w1c_s;
  logic              hit_s;
  gpio_off_t         off_s;
  logic [OUT_W-1:0]  led_q, led_d;
  logic [IN_W-1:0]   changed_q, changed_d;
  logic [IN_W-1:0]   mask_q, mask_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_hit_q, rd_hit_d;

  gpio_debounce #(
    .WIDTH           (IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .raw_i (switches),
    .deb_o (deb_s),
    .chg_o (chg_s)
  );

  assign hit_s = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign off_s = gpio_off_t'(addr[1:0]);

  // Decode writes and reads; a new change on a bit wins over a concurrent clear.
  always_comb begin
    led_d     = led_q;
    mask_d    = mask_q;
    w1c_s     = '0;
    rd_data_d = '0;
    if (hit_s && wr_en) begin
      case (off_s)
        OFF_LED:      led_d  = wr_data[OUT_W-1:0];
        OFF_CHANGED:  w1c_s  = wr_data[IN_W-1:0];
        OFF_IRQ_MASK: mask_d = wr_data[IN_W-1:0];
        default:      led_d  = led_q;
      endcase
    end else begin
      w1c_s = '0;
    end
    if (hit_s) begin
      case (off_s)
        OFF_SW_VAL:   rd_data_d = DATA_W'(deb_s);
        OFF_LED:      rd_data_d = DATA_W'(led_q);
        OFF_CHANGED:  rd_data_d = DATA_W'(changed_q);
        OFF_IRQ_MASK: rd_data_d = DATA_W'(mask_q);
        default:      rd_data_d = '0;
      endcase
    end else begin
      rd_data_d = '0;
    end
    changed_d = (changed_q & ~w1c_s) | chg_s;
    irq_d     = |(changed_q & mask_q);
    rd_hit_d  = hit_s;
  end

  // Register file, interrupt and read-port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= '0;
      changed_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      led_q     <= led_d;
      changed_q <= changed_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  assign leds    = led_q;
  assign irq     = irq_q;
  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;

endmodule

// File: tb/tb_gpio_mapped_io.sv
// tb_gpio_mapped_io: directed self-checking bench for gpio_mapped_io with
// DEBOUNCE_CYCLES=4 and BASE_ADDR=16'hFFF0. Expectations that depend on the
// GPIO_DEBOUNCE_EN build option are selected with the same macro.
module tb_gpio_mapped_io;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_hit;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        irq;
  logic [15:0] d;
  int          n_checks = 0;
  int          n_pass   = 0;

  gpio_mapped_io #(
    .DATA_W          (16),
    .ADDR_W          (16),
    .IN_W            (16),
    .OUT_W           (16),
    .BASE_ADDR       (16'hFFF0),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    addr  = a;
    wr_en = 1'b0;
    step(1);
    v     = rd_data;
    addr  = 16'h0000;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    addr    = a;
    wr_en   = 1'b1;
    wr_data = v;
    step(1);
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    addr    = 16'h0000;
  endtask

  // Poll SW_VAL each cycle for a bounded number of cycles.
  task automatic wait_sw(input string tag, input logic [15:0] exp, input int budget);
    addr  = 16'hFFF0;
    wr_en = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (rd_data == exp) break;
    end
    check_eq(tag, rd_data, exp);
    addr = 16'h0000;
  endtask

  initial begin
    reset    = 1'b1;
    switches = 16'h0007;
    addr     = 16'h0000;
    wr_en    = 1'b0;
    wr_data  = 16'h0000;
    step(4);
    check_eq("rst_leds", leds, 16'h0000);
    check_eq("rst_rd_data", rd_data, 16'h0000);
    check_eq("rst_rd_hit", {15'd0, rd_hit}, 16'h0000);
    check_eq("rst_irq", {15'd0, irq}, 16'h0000);

    // Prime path: switches loaded without flagging a change.
    reset = 1'b0;
    step(20);
    bus_read(16'hFFF0, d);
    check_eq("prime_sw_val", d, 16'h0007);
    check_eq("hit_rd_hit", {15'd0, rd_hit}, 16'h0001);
    bus_read(16'hFFF2, d);
    check_eq("prime_changed", d, 16'h0000);
    bus_read(16'hFFF3, d);
    check_eq("rst_mask", d, 16'h0000);
    bus_read(16'h1231, d);
    check_eq("miss_rd_data", d, 16'h0000);
    check_eq("miss_rd_hit", {15'd0, rd_hit}, 16'h0000);

    // Switch change 7 -> 5 with bit 1 unmasked.
    bus_write(16'hFFF3, 16'h0002);
    bus_read(16'hFFF3, d);
    check_eq("mask_rb", d, 16'h0002);
    switches = 16'h0005;
    wait_sw("sw_7to5", 16'h0005, 14);
    check_eq("irq_set", {15'd0, irq}, 16'h0001);
    bus_read(16'hFFF2, d);
    check_eq("changed_b1", d, 16'h0002);
    bus_write(16'hFFF2, 16'h0002);
    step(1);
    check_eq("irq_clr", {15'd0, irq}, 16'h0000);
    bus_read(16'hFFF2, d);
    check_eq("changed_w1c", d, 16'h0000);

    // LED register, write to read-only SW_VAL, non-hit write.
    bus_write(16'hFFF1, 16'hA5A5);
    check_eq("leds_wr", leds, 16'hA5A5);
    bus_read(16'hFFF1, d);
    check_eq("leds_rb", d, 16'hA5A5);
    bus_write(16'hFFF0, 16'hFFFF);
    bus_read(16'hFFF0, d);
    check_eq("sw_val_ro", d, 16'h0005);
    bus_write(16'h1231, 16'h0000);
    check_eq("miss_wr_leds", leds, 16'hA5A5);

    // 3-cycle glitch on switches[4].
    switches = 16'h0015;
    step(3);
    switches = 16'h0005;
    step(20);
    bus_read(16'hFFF0, d);
    check_eq("glitch_sw_val", d, 16'h0005);
    bus_read(16'hFFF2, d);
`ifdef GPIO_DEBOUNCE_EN
    check_eq("glitch_changed", d, 16'h0000);
`else
    check_eq("glitch_changed", d, 16'h0010);
    bus_write(16'hFFF2, 16'h0010);
`endif

    // Bit 0 change, then zero-write to CHANGED has no effect.
    switches = 16'h0004;
    wait_sw("sw_5to4", 16'h0004, 14);
    bus_read(16'hFFF2, d);
    check_eq("changed_b0", d, 16'h0001);
    bus_write(16'hFFF2, 16'h0000);
    bus_read(16'hFFF2, d);
    check_eq("w0_no_effect", d, 16'h0001);

    // Continuous W1C of bits 0 and 1 while bit 1 changes: set must win.
    switches = 16'h0006;
    addr     = 16'hFFF2;
    wr_en    = 1'b1;
    wr_data  = 16'h0003;
    step(1);
    check_eq("w1c_pre", rd_data, 16'h0001);
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (rd_data != 16'h0000) break;
    end
    check_eq("set_wins", rd_data, 16'h0002);
    check_eq("set_wins_irq", {15'd0, irq}, 16'h0001);
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    addr    = 16'h0000;
    bus_read(16'hFFF2, d);
    check_eq("w1c_after", d, 16'h0000);

    // Reset mid-debounce, then re-prime from current switches.
    switches = 16'h00F0;
    step(2);
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_leds", leds, 16'h0000);
    check_eq("mid_rst_rd_hit", {15'd0, rd_hit}, 16'h0000);
    check_eq("mid_rst_irq", {15'd0, irq}, 16'h0000);
    step(4);
    reset = 1'b0;
    step(20);
    bus_read(16'hFFF0, d);
    check_eq("reprime_sw_val", d, 16'h00F0);
    bus_read(16'hFFF2, d);
    check_eq("reprime_changed", d, 16'h0000);
    bus_read(16'hFFF3, d);
    check_eq("reprime_mask", d, 16'h0000);
    bus_read(16'hFFF1, d);
    check_eq("reprime_leds", d, 16'h0000);
    check_eq("reprime_irq", {15'd0, irq}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
